// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Drives the register-file write strobes and mux selects, and handshakes with memory.
module control_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ir_opcode,
  input  logic        acc_zero,
  input  logic        acc_neg,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        mar_write,
  output logic        mbr_write,
  output logic        ir_write,
  output logic        acc_write,
  output logic        pc_sel,
  output logic        mar_sel,
  output logic        mbr_sel,
  output logic        acc_sel,
  output logic        alu_sub,
  output logic        mem_req,
  output logic        mem_we,
  output logic        halted,
  output logic        bus_error,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_FA, S_FM, S_FI, S_DEC, S_EA, S_EM, S_WB, S_HLT
  } state_t;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_JZ    = 4'h6;
  localparam logic [3:0] OP_JN    = 4'h7;
  localparam logic [3:0] OP_NOP   = 4'h8;

  // Bus error fires on the wait cycle whose count reaches TIMEOUT.
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] retired_q;
  logic        bus_error_q, bus_error_d;
  logic        illegal_q, illegal_d;
  logic        retire;
  logic        timed_out;

  logic pc_write_c, mar_write_c, mbr_write_c, ir_write_c, acc_write_c;
  logic pc_sel_c, mar_sel_c, mbr_sel_c, acc_sel_c, alu_sub_c;
  logic mem_req_c, mem_we_c;

  assign timed_out = (TIMEOUT != 0) && !mem_ready && (wait_q == WAIT_LIMIT);

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    bus_error_d = bus_error_q;
    illegal_d   = illegal_q;
    retire      = 1'b0;
    pc_write_c  = 1'b0;
    mar_write_c = 1'b0;
    mbr_write_c = 1'b0;
    ir_write_c  = 1'b0;
    acc_write_c = 1'b0;
    pc_sel_c    = 1'b0;
    mar_sel_c   = 1'b0;
    mbr_sel_c   = 1'b0;
    acc_sel_c   = 1'b0;
    alu_sub_c   = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;

    case (state_q)
      S_FA: begin
        mar_write_c = 1'b1;
        state_d     = S_FM;
      end
      S_FM: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          mbr_write_c = 1'b1;
          pc_write_c  = 1'b1;
          state_d     = S_FI;
        end else begin
          wait_d = wait_q + 16'd1;
          if (timed_out) begin
            bus_error_d = 1'b1;
            state_d     = S_HLT;
          end
        end
      end
      S_FI: begin
        ir_write_c = 1'b1;
        state_d    = S_DEC;
      end
      S_DEC: begin
        case (ir_opcode)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB: state_d = S_EA;
          OP_JMP: begin
            pc_write_c = 1'b1;
            pc_sel_c   = 1'b1;
            retire     = 1'b1;
            state_d    = S_FA;
          end
          OP_JZ, OP_JN: begin
            if ((ir_opcode == OP_JZ) ? acc_zero : acc_neg) begin
              pc_write_c = 1'b1;
              pc_sel_c   = 1'b1;
            end
            retire  = 1'b1;
            state_d = S_FA;
          end
          OP_NOP: begin
            retire  = 1'b1;
            state_d = S_FA;
          end
          OP_HALT: begin
            retire  = 1'b1;
            state_d = S_HLT;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HLT;
          end
        endcase
      end
      S_EA: begin
        mar_write_c = 1'b1;
        mar_sel_c   = 1'b1;
        if (ir_opcode == OP_STORE) begin
          mbr_write_c = 1'b1;
          mbr_sel_c   = 1'b1;
        end
        state_d = S_EM;
      end
      S_EM: begin
        mem_req_c = 1'b1;
        mem_we_c  = (ir_opcode == OP_STORE);
        if (mem_ready) begin
          if (ir_opcode == OP_STORE) begin
            retire  = 1'b1;
            state_d = S_FA;
          end else begin
            mbr_write_c = 1'b1;
            state_d     = S_WB;
          end
        end else begin
          wait_d = wait_q + 16'd1;
          if (timed_out) begin
            bus_error_d = 1'b1;
            state_d     = S_HLT;
          end
        end
      end
      S_WB: begin
        acc_write_c = 1'b1;
        acc_sel_c   = (ir_opcode == OP_ADD) || (ir_opcode == OP_SUB);
        alu_sub_c   = (ir_opcode == OP_SUB);
        retire      = 1'b1;
        state_d     = S_FA;
      end
      S_HLT: state_d = S_HLT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FA;
      wait_q      <= '0;
      bus_error_q <= 1'b0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      bus_error_q <= bus_error_d;
      illegal_q   <= illegal_d;
      if (retire) retired_q <= retired_q + 16'd1;
    end
  end

  // Every output is held low while reset is asserted, including the status.
  assign pc_write  = !reset && pc_write_c;
  assign mar_write = !reset && mar_write_c;
  assign mbr_write = !reset && mbr_write_c;
  assign ir_write  = !reset && ir_write_c;
  assign acc_write = !reset && acc_write_c;
  assign pc_sel    = !reset && pc_sel_c;
  assign mar_sel   = !reset && mar_sel_c;
  assign mbr_sel   = !reset && mbr_sel_c;
  assign acc_sel   = !reset && acc_sel_c;
  assign alu_sub   = !reset && alu_sub_c;
  assign mem_req   = !reset && mem_req_c;
  assign mem_we    = !reset && mem_we_c;
  assign halted    = !reset && (state_q == S_HLT);
  assign bus_error = !reset && bus_error_q;
  assign illegal   = !reset && illegal_q;
  assign retired   = reset ? 16'h0000 : retired_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a small datapath and memory model follow the strobes,
// and per-cycle expected output vectors are queued and drained against the DUT.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ir_opcode;
  logic        acc_zero, acc_neg, mem_ready;
  logic        pc_write, mar_write, mbr_write, ir_write, acc_write;
  logic        pc_sel, mar_sel, mbr_sel, acc_sel, alu_sub;
  logic        mem_req, mem_we, halted, bus_error, illegal;
  logic [15:0] retired;

  control_unit #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .ir_opcode(ir_opcode), .acc_zero(acc_zero),
    .acc_neg(acc_neg), .mem_ready(mem_ready), .pc_write(pc_write),
    .mar_write(mar_write), .mbr_write(mbr_write), .ir_write(ir_write),
    .acc_write(acc_write), .pc_sel(pc_sel), .mar_sel(mar_sel),
    .mbr_sel(mbr_sel), .acc_sel(acc_sel), .alu_sub(alu_sub),
    .mem_req(mem_req), .mem_we(mem_we), .halted(halted),
    .bus_error(bus_error), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [14:0] M_PCW  = 15'd1 << 14;
  localparam logic [14:0] M_MARW = 15'd1 << 13;
  localparam logic [14:0] M_MBRW = 15'd1 << 12;
  localparam logic [14:0] M_IRW  = 15'd1 << 11;
  localparam logic [14:0] M_ACCW = 15'd1 << 10;
  localparam logic [14:0] M_PCS  = 15'd1 << 9;
  localparam logic [14:0] M_MARS = 15'd1 << 8;
  localparam logic [14:0] M_MBRS = 15'd1 << 7;
  localparam logic [14:0] M_ACCS = 15'd1 << 6;
  localparam logic [14:0] M_SUB  = 15'd1 << 5;
  localparam logic [14:0] M_REQ  = 15'd1 << 4;
  localparam logic [14:0] M_WE   = 15'd1 << 3;
  localparam logic [14:0] M_HALT = 15'd1 << 2;
  localparam logic [14:0] M_BERR = 15'd1 << 1;
  localparam logic [14:0] M_ILL  = 15'd1 << 0;

  logic [14:0] obs;
  assign obs = {pc_write, mar_write, mbr_write, ir_write, acc_write, pc_sel, mar_sel,
                mbr_sel, acc_sel, alu_sub, mem_req, mem_we, halted, bus_error, illegal};

  // Datapath and memory environment
  logic [15:0] mem [4096];
  logic [15:0] pc_m, mbr_m, ir_m;
  logic [15:0] acc_m = 16'h0000;
  logic [11:0] mar_m, wr_addr_m;
  logic [15:0] wr_data_m;
  logic [7:0]  req_cnt;
  logic [7:0]  wr_delay;
  logic        mem_dead;

  assign ir_opcode = ir_m[15:12];
  assign acc_zero  = (acc_m == 16'h0000);
  assign acc_neg   = acc_m[15];

  always_comb mem_ready = mem_req && !mem_dead && (req_cnt >= (mem_we ? wr_delay : 8'd0));

  always @(posedge clk) begin
    if (reset) begin
      pc_m <= '0; mar_m <= '0; mbr_m <= '0; ir_m <= '0; req_cnt <= '0;
    end else begin
      req_cnt <= (mem_req && !mem_ready) ? req_cnt + 8'd1 : 8'd0;
      if (pc_write)  pc_m  <= pc_sel ? {4'h0, ir_m[11:0]} : pc_m + 16'd1;
      if (mar_write) mar_m <= mar_sel ? ir_m[11:0] : pc_m[11:0];
      if (mbr_write) mbr_m <= mbr_sel ? acc_m : mem[mar_m];
      if (ir_write)  ir_m  <= mbr_m;
      if (acc_write) acc_m <= acc_sel ? (alu_sub ? acc_m - mbr_m : acc_m + mbr_m) : mbr_m;
      if (mem_req && mem_we && mem_ready) begin
        wr_addr_m <= mar_m;
        wr_data_m <= mbr_m;
      end
    end
  end

  typedef struct packed {
    logic [14:0] v;
    logic [15:0] ret;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_ret;
  int          total = 0;
  int          bad = 0;
  int          cyc;

  function automatic void push(input logic [14:0] v, input bit r);
    exp_t e;
    e.v   = v;
    e.ret = exp_ret;
    sb.push_back(e);
    if (r) exp_ret = exp_ret + 16'd1;
  endfunction

  function automatic void push_fetch();
    push(M_MARW, 1'b0);
    push(M_REQ | M_MBRW | M_PCW, 1'b0);
    push(M_IRW, 1'b0);
  endfunction

  // EA, EM, WB of a zero-wait LOAD/ADD/SUB; the WB vector differs per opcode.
  function automatic void push_exec_rd(input logic [14:0] wb_v);
    push(M_MARW | M_MARS, 1'b0);
    push(M_REQ | M_MBRW, 1'b0);
    push(wb_v, 1'b1);
  endfunction

  task automatic run_sb(input string name);
    exp_t e;
    cyc = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      #1;
      total++;
      if (obs !== e.v || retired !== e.ret) begin
        bad++;
        $display("FAIL %s cycle=%0d outputs=%h expected=%h retired=%h expected=%h",
                 name, cyc, obs, e.v, retired, e.ret);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h8000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (obs !== 15'h0 || retired !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs outputs=%h retired=%h expected=0", obs, retired);
    end
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    exp_ret = '0;
  endtask

  task automatic test_nop();
    clear_mem();
    do_reset();
    push_fetch();
    push(15'h0, 1'b1);
    push(M_MARW, 1'b0);
    run_sb("nop");
  endtask

  task automatic test_load_add();
    clear_mem();
    mem[0] = 16'h1010; mem[1] = 16'h3011; mem[16'h10] = 16'd5; mem[16'h11] = 16'd7;
    do_reset();
    push_fetch(); push(15'h0, 1'b0); push_exec_rd(M_ACCW);
    push_fetch(); push(15'h0, 1'b0); push_exec_rd(M_ACCW | M_ACCS);
    push(M_MARW, 1'b0);
    run_sb("load_add");
    total++;
    if (acc_m !== 16'd12) begin
      bad++;
      $display("FAIL load_add_acc acc=%h expected=%h", acc_m, 16'd12);
    end
  endtask

  task automatic test_store_wait();
    clear_mem();
    mem[0] = 16'h1030; mem[1] = 16'h2020; mem[16'h30] = 16'h1234;
    wr_delay = 8'd3;
    do_reset();
    push_fetch(); push(15'h0, 1'b0); push_exec_rd(M_ACCW);
    push_fetch(); push(15'h0, 1'b0);
    push(M_MARW | M_MARS | M_MBRW | M_MBRS, 1'b0);
    for (int i = 0; i < 3; i++) push(M_REQ | M_WE, 1'b0);
    push(M_REQ | M_WE, 1'b1);
    push(M_MARW, 1'b0);
    run_sb("store_wait");
    total++;
    if (wr_addr_m !== 12'h020 || wr_data_m !== 16'h1234) begin
      bad++;
      $display("FAIL store_data addr=%h data=%h expected addr=020 data=1234",
               wr_addr_m, wr_data_m);
    end
    wr_delay = 8'd0;
  endtask

  task automatic test_jz();
    clear_mem();
    mem[0] = 16'h1040; mem[1] = 16'h6050; mem[16'h40] = 16'h0000;
    do_reset();
    push_fetch(); push(15'h0, 1'b0); push_exec_rd(M_ACCW);
    push_fetch(); push(M_PCW | M_PCS, 1'b1);
    push(M_MARW, 1'b0);
    run_sb("jz_taken");
    total++;
    if (mar_m !== 12'h050) begin
      bad++;
      $display("FAIL jz_taken_fetch mar=%h expected=050", mar_m);
    end
    mem[0] = 16'h1041; mem[16'h41] = 16'h0001;
    do_reset();
    push_fetch(); push(15'h0, 1'b0); push_exec_rd(M_ACCW);
    push_fetch(); push(15'h0, 1'b1);
    push(M_MARW, 1'b0);
    run_sb("jz_not_taken");
    total++;
    if (mar_m !== 12'h002) begin
      bad++;
      $display("FAIL jz_not_taken_fetch mar=%h expected=002", mar_m);
    end
  endtask

  task automatic test_sub_jn_jmp();
    clear_mem();
    mem[0] = 16'h1010; mem[1] = 16'h4011; mem[2] = 16'h7050;
    mem[16'h10] = 16'd5; mem[16'h11] = 16'd7; mem[16'h50] = 16'h5060;
    do_reset();
    push_fetch(); push(15'h0, 1'b0); push_exec_rd(M_ACCW);
    push_fetch(); push(15'h0, 1'b0); push_exec_rd(M_ACCW | M_ACCS | M_SUB);
    push_fetch(); push(M_PCW | M_PCS, 1'b1);
    push_fetch(); push(M_PCW | M_PCS, 1'b1);
    push(M_MARW, 1'b0);
    run_sb("sub_jn_jmp");
    total++;
    if (acc_m !== 16'hFFFE || mar_m !== 12'h060) begin
      bad++;
      $display("FAIL sub_jn_jmp_state acc=%h mar=%h expected acc=fffe mar=060", acc_m, mar_m);
    end
  endtask

  task automatic test_halt_illegal();
    clear_mem();
    mem[0] = 16'h0000;
    do_reset();
    push_fetch(); push(15'h0, 1'b1);
    push(M_HALT, 1'b0); push(M_HALT, 1'b0); push(M_HALT, 1'b0);
    run_sb("halt");
    mem[0] = 16'hB000;
    do_reset();
    push_fetch(); push(15'h0, 1'b0);
    push(M_HALT | M_ILL, 1'b0); push(M_HALT | M_ILL, 1'b0); push(M_HALT | M_ILL, 1'b0);
    run_sb("illegal");
  endtask

  task automatic test_timeout();
    clear_mem();
    mem_dead = 1'b1;
    do_reset();
    push(M_MARW, 1'b0);
    for (int i = 0; i < 15; i++) push(M_REQ, 1'b0);
    push(M_HALT | M_BERR, 1'b0); push(M_HALT | M_BERR, 1'b0);
    run_sb("timeout");
    mem_dead = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_mem();
    mem[0] = 16'h1010; mem[1] = 16'h1011; mem[16'h10] = 16'h0005; mem[16'h11] = 16'h0099;
    do_reset();
    push_fetch(); push(15'h0, 1'b0); push_exec_rd(M_ACCW);
    push_fetch(); push(15'h0, 1'b0); push(M_MARW | M_MARS, 1'b0);
    run_sb("reset_mid_pre");
    reset = 1'b1;
    #1;
    total++;
    if (obs !== 15'h0 || retired !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid_outputs outputs=%h retired=%h expected=0", obs, retired);
    end
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    exp_ret = '0;
    push(M_MARW, 1'b0);
    push(M_REQ | M_MBRW | M_PCW, 1'b0);
    run_sb("reset_mid_restart");
    total++;
    if (acc_m !== 16'h0005) begin
      bad++;
      $display("FAIL reset_mid_acc acc=%h expected=0005", acc_m);
    end
  endtask

  initial begin
    reset    = 1'b1;
    mem_dead = 1'b0;
    wr_delay = 8'd0;
    exp_ret  = '0;
    @(negedge clk);
    test_nop();
    test_load_add();
    test_store_wait();
    test_jz();
    test_sub_jn_jmp();
    test_halt_illegal();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencing controller for the 16-bit accumulator CPU. It is the initiator side of the register-file write-enable interface: it drives the PC, MAR, MBR, IR and ACC write strobes and the input-mux selects, and handshakes with memory. It walks a fetch/decode/execute state machine over a 4-bit opcode / 12-bit address instruction format. It also reports halt, bus-error and retired-instruction status.

## Interface
- TIMEOUT, 15: max memory wait cycles with `mem_ready` low before bus error; 0 disables the timeout.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ir_opcode  in  4  IR[15:12] from the instruction register.
- acc_zero  in  1  ACC == 0.
- acc_neg  in  1  ACC[15].
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write, mar_write, mbr_write, ir_write, acc_write  out  1 each  register write strobes.
- pc_sel  out  1  0: PC+1, 1: IR[11:0] zero-extended.
- mar_sel  out  1  0: PC, 1: IR[11:0].
- mbr_sel  out  1  0: memory read data, 1: ACC.
- acc_sel  out  1  0: MBR, 1: ALU result.
- alu_sub  out  1  0: ACC+MBR, 1: ACC−MBR.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write (MBR → mem[MAR]).
- halted  out  1  sticky halt.
- bus_error  out  1  sticky; halt was caused by memory timeout.
- illegal  out  1  sticky; halt was caused by an undefined opcode.
- retired  out  16  count of completed instructions; wraps 0xFFFF→0.

## Operation
- Opcodes: 0 HALT, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 JMP, 6 JZ, 7 JN, 8 NOP. Opcodes 9–F are illegal.
- States: FA, FM, FI, DEC, EA, EM, WB, HLT.
- FA: mar_write=1, mar_sel=0. Next state FM.
- FM: mem_req=1, mem_we=0. When mem_ready=1: mbr_write=1, mbr_sel=0, pc_write=1, pc_sel=0, next state FI. Otherwise stay in FM.
- FI: ir_write=1 (IR←MBR). Next state DEC.
- DEC behaviour by opcode:
  - LOAD/ADD/SUB/STORE → EA.
  - JMP: pc_write=1, pc_sel=1, retire, → FA.
  - JZ/JN: if the flag is set, pc_write=1, pc_sel=1. In both cases retire and → FA.
  - NOP: retire, → FA.
  - HALT: retire, → HLT.
  - Illegal: set illegal, → HLT; no retire.
- EA: mar_write=1, mar_sel=1. For STORE also mbr_write=1, mbr_sel=1. → EM.
- EM: mem_req=1, mem_we=1 for STORE, else 0.
  - On mem_ready with LOAD/ADD/SUB: mbr_write=1, mbr_sel=0, → WB.
  - On mem_ready with STORE: retire, → FA.
- WB: acc_write=1. acc_sel=0 for LOAD, 1 for ADD/SUB; alu_sub=1 for SUB only. Retire, → FA.
- HLT: all strobes and mem_req are 0, halted=1. Only reset leaves HLT.
- Wait counter: clears on entry to FM/EM and on every mem_ready. It increments each FM/EM cycle with mem_ready=0. If TIMEOUT≠0 and the counter reaches TIMEOUT with mem_ready still 0: set bus_error, → HLT, drop mem_req the next cycle.
- Retire: retired increments by 1 on the retiring cycle.
- All selects and alu_sub are 0 in any cycle where they are not listed above.

## Timing
- Strobes, selects and mem_req/mem_we are combinational from state, ir_opcode, flags and mem_ready. The state and sticky flags are registered.
- While reset=1, all outputs are forced to 0. At the first edge with reset=1: state←FA, halted/bus_error/illegal←0, retired←0, wait counter←0.
- Reset mid-instruction aborts it immediately; no partial strobe is issued after the reset edge.
- Cycles per instruction with zero-wait memory (mem_ready high on the first request cycle):
  - LOAD/ADD/SUB: 7.
  - STORE: 6.
  - JMP/JZ/JN/NOP/HALT: 4.
  - Each memory wait cycle adds 1.
- Flags are sampled in the DEC cycle only.
- mem_req stays high continuously until the mem_ready cycle. mem_we is stable for that whole span.

## Test plan
- Reset, then NOP at addr 0, zero-wait memory → strobe sequence mar_write, mbr_write+pc_write, ir_write; retired=1 at cycle 4; MAR select 0 in FA.
- LOAD 0x010 followed by ADD 0x011 (mem[0x10]=5, mem[0x11]=7) → ACC=12, retired=2 after 14 cycles; alu_sub=0 and acc_sel=1 in the ADD WB cycle.
- STORE 0x020 with ACC=0x1234, mem_ready delayed 3 cycles → mem_we=1 with mem_req held for 4 cycles; mem[0x20]=0x1234; instruction takes 9 cycles.
- JZ 0x050 with acc_zero=1 → pc_write with pc_sel=1 in DEC, next fetch at 0x050. With acc_zero=0 → next fetch at PC+1.
- Opcode 0xB → illegal=1, halted=1, retired unchanged. mem_ready never asserted with TIMEOUT=15 → bus_error=1 after 15 wait cycles.
- Reset asserted mid-EM of LOAD → all outputs 0 during reset; restart at FA with retired=0 and ACC untouched by the aborted instruction.
